// File: rtl/audio_sample_fifo_if.sv
// audio_sample_fifo_if: sample FIFO push, status and I2S frame signals
interface audio_sample_fifo_if #(parameter int DEPTH_LOG2 = 8);
    logic                  i_write;
    logic [31:0]           i_write_data;
    logic                  o_full;
    logic                  o_empty;
    logic [DEPTH_LOG2:0]   o_level;
    logic                  o_low;
    logic                  o_overflow;
    logic [15:0]           o_underrun_count;
    logic                  i_clear_status;
    logic                  i_flush;
    logic                  i_sample_clock;
    logic [15:0]           o_sample_left;
    logic [15:0]           o_sample_right;
    modport master (
        output i_write, i_write_data, i_clear_status, i_flush, i_sample_clock,
        input  o_full, o_empty, o_level, o_low, o_overflow, o_underrun_count,
               o_sample_left, o_sample_right
    );
    modport slave (
        input  i_write, i_write_data, i_clear_status, i_flush, i_sample_clock,
        output o_full, o_empty, o_level, o_low, o_overflow, o_underrun_count,
               o_sample_left, o_sample_right
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: stereo sample buffer feeding the I2S stage, one pair per sample-clock toggle
module audio_sample_fifo #(
    parameter int DEPTH_LOG2    = 8,
    parameter int LOW_WATERMARK = 64
) (
    input logic              i_clock,
    input logic              i_reset_n,
    audio_sample_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  full_q, full_d, empty_q, empty_d, low_q, low_d;
    logic                  overflow_q, overflow_d, last_sc_q, armed_q;
    logic [15:0]           underrun_q, underrun_d, left_q, left_d, right_q, right_d;
    logic                  req, do_push, do_pop, underrun_ev;
    logic [31:0]           head;

    // next-state: flush overrides everything, fullness is judged before any same-cycle pop
    always_comb begin
        req         = armed_q && (bus.i_sample_clock != last_sc_q);
        do_push     = bus.i_write && !full_q && !bus.i_flush;
        do_pop      = req && !empty_q && !bus.i_flush;
        underrun_ev = req && empty_q && !bus.i_flush;
        head        = mem_q[rd_ptr_q];
        wr_ptr_d    = bus.i_flush ? '0 : wr_ptr_q + DEPTH_LOG2'(do_push);
        rd_ptr_d    = bus.i_flush ? '0 : rd_ptr_q + DEPTH_LOG2'(do_pop);
        level_d     = bus.i_flush ? '0 : level_q + LW'(do_push) - LW'(do_pop);
        full_d      = level_d == LW'(DEPTH);
        empty_d     = level_d == '0;
        low_d       = int'(level_d) < LOW_WATERMARK;
        overflow_d  = bus.i_clear_status ? 1'b0 :
                      overflow_q | (bus.i_write && full_q && !bus.i_flush);
        underrun_d  = bus.i_clear_status ? 16'h0 :
                      (underrun_ev && underrun_q != 16'hFFFF) ? underrun_q + 16'd1 : underrun_q;
        left_d      = (bus.i_flush || underrun_ev) ? 16'h0 : do_pop ? head[31:16] : left_q;
        right_d     = (bus.i_flush || underrun_ev) ? 16'h0 : do_pop ? head[15:0] : right_q;
    end

    // control and status registers
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            low_q      <= LOW_WATERMARK > 0;
            overflow_q <= 1'b0;
            underrun_q <= 16'h0;
            left_q     <= 16'h0;
            right_q    <= 16'h0;
            last_sc_q  <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            low_q      <= low_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
            left_q     <= left_d;
            right_q    <= right_d;
            last_sc_q  <= bus.i_sample_clock;
            armed_q    <= 1'b1;
        end
    end

    // sample storage, written only on accepted pushes
    always_ff @(posedge i_clock) begin
        if (do_push) mem_q[wr_ptr_q] <= bus.i_write_data;
    end

    assign bus.o_full           = full_q;
    assign bus.o_empty          = empty_q;
    assign bus.o_level          = level_q;
    assign bus.o_low            = low_q;
    assign bus.o_overflow       = overflow_q;
    assign bus.o_underrun_count = underrun_q;
    assign bus.o_sample_left    = left_q;
    assign bus.o_sample_right   = right_q;
endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
Stereo sample buffer directly upstream of the I2S output stage. The CPU/DMA side pushes packed 32-bit stereo words. The block presents one left/right pair per output frame, advancing whenever the I2S stage's sample-clock toggle signal changes level. It also reports fill level, low-watermark, overflow and underrun status for the audio register block.

Parameters:
DEPTH_LOG2, 8, FIFO depth is 2**DEPTH_LOG2 stereo words (default 256).
LOW_WATERMARK, 64, o_low asserted while level is strictly below this value.

Ports:
i_clock  in  1  system clock; all logic on rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_write  in  1  push request, one word per cycle
i_write_data  in  32  [31:16] left sample, [15:0] right sample (signed PCM)
o_full  out  1  level == 2**DEPTH_LOG2
o_empty  out  1  level == 0
o_level  out  DEPTH_LOG2+1  current occupancy
o_low  out  1  level < LOW_WATERMARK
o_overflow  out  1  sticky: write attempted while full
o_underrun_count  out  16  saturating count of frames served while empty
i_clear_status  in  1  clears o_overflow and o_underrun_count
i_flush  in  1  discard all buffered words
i_sample_clock  in  1  toggle-per-frame request from the I2S output stage (same clock domain)
o_sample_left  out  16  left sample for the current frame
o_sample_right  out  16  right sample for the current frame

Behaviour:
- Async reset (i_reset_n=0): pointers=0, level=0, o_empty=1, o_full=0, o_low=1 (for LOW_WATERMARK>0), o_overflow=0, o_underrun_count=0, o_sample_left/right=0, last_sc=0, armed=0.
- Toggle detect: register last_sc <= i_sample_clock every cycle. A request fires when armed=1 and i_sample_clock != last_sc. armed is set on the first clock after reset release; that cycle only captures last_sc, so there is no spurious request whatever the level of i_sample_clock.
- Pop on request: if not empty, the head word is latched into o_sample_left/right on the same edge the request is detected. Outputs are therefore valid 1 cycle after i_sample_clock changes. The read pointer increments.
- Underrun on request with empty FIFO: outputs forced to 0. o_underrun_count increments, saturating at 16'hFFFF. There is no write-to-read bypass: a write in the same cycle does not satisfy that request.
- Push: i_write with FIFO not full stores the word and increments the write pointer. i_write while full drops the word, sets o_overflow and leaves state unchanged.
- Simultaneous push and pop (not full, not empty): both occur and level is unchanged.
- Full FIFO with simultaneous push and pop: the push is still rejected and flagged, because fullness is evaluated before the pop.
- Pointers are DEPTH_LOG2 bits wide and wrap naturally. Level is a separate DEPTH_LOG2+1-bit counter.
- Flush: highest priority. Pointers and level go to 0, and outputs go to 0. A same-cycle write is discarded without setting overflow. A same-cycle request produces no underrun count. last_sc is still updated.
- i_clear_status: clears o_overflow and o_underrun_count to 0. If an overflow or underrun event occurs in the same cycle, the clear wins.
- Status outputs (o_full, o_empty, o_level, o_low) are registered and reflect state after the current edge.
- Storage is a simple dual-port RAM with registered write and combinational or registered read. If read is registered, the head word is prefetched so the 1-cycle output latency holds.

Test Plan:
- Reset release with i_sample_clock=1 held, then 10 idle cycles -> o_underrun_count=0, outputs 0, o_empty=1, o_low=1.
- Push 0x1234_ABCD and 0x7FFF_8000, then toggle i_sample_clock twice (20 cycles apart) -> left/right = 0x1234/0xABCD one cycle after the first toggle, 0x7FFF/0x8000 after the second; o_level goes 2,1,0.
- Push 256 words (DEPTH_LOG2=8), then one more -> o_full=1, o_level=256, o_overflow=1, and the 257th word is never output. Pop all 256 -> values in order with the pointer wrapping; i_clear_status -> o_overflow=0.
- Toggle 3 times while empty -> outputs 0 and o_underrun_count=3. Force the count to 0xFFFF with repeated toggles, toggle once more -> count stays 0xFFFF.
- Simultaneous write and toggle with level=5 -> level stays 5 and the correct head is output. With level=0 -> the request underruns and level ends at 1.
- Fill with 100 words, assert i_flush together with i_write and a toggle -> level=0, outputs 0, no overflow, underrun count unchanged. o_low is 0 at level 64 and 1 at level 63.
